// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle RV32I-subset CPU: opcodes, control state codes,
// ALUop encodings and datapath mux-select codes.
package cpu_defs_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        ALU_WB    = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        MEM_WB    = 4'd7,
        MEM_WRITE = 4'd8,
        BRANCH    = 4'd9,
        JAL       = 4'd10
    } state_t;

    localparam logic [1:0] ALUOP_ADD  = 2'b10;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_A     = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    localparam logic [1:0] M2R_ALU    = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic IORD_PC     = 1'b0;
    localparam logic IORD_ALUOUT = 1'b1;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    // R-type ALUop: add/sub resolved here, OR/XOR deferred to ALUcontrol via func.
    function automatic logic [1:0] r_alu_op(input logic [3:0] func);
        logic [1:0] op;
        op = ALUOP_ADD;
        if (func == 4'b1000)
            op = ALUOP_SUB;
        else if (func[2:0] == 3'b110 || func[2:0] == 3'b100)
            op = ALUOP_FUNC;
        return op;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the main control FSM (slave side) and the datapath/IR (master side).
interface mc_control_fsm_if #(
    parameter int unsigned STATE_W = 4
);
    logic               cpu_en;
    logic [6:0]         opcode;
    logic [3:0]         func;
    logic               zero;
    logic               lt;
    logic               pc_we;
    logic               iord;
    logic               mem_rd;
    logic               mem_we;
    logic               ir_we;
    logic               reg_we;
    logic [1:0]         mem2reg;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic               pc_src;
    logic               illegal;
    logic [STATE_W-1:0] dbg_state;

    modport master (
        output cpu_en, opcode, func, zero, lt,
        input  pc_we, iord, mem_rd, mem_we, ir_we, reg_we, mem2reg,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal, dbg_state
    );

    modport slave (
        input  cpu_en, opcode, func, zero, lt,
        output pc_we, iord, mem_rd, mem_we, ir_we, reg_we, mem2reg,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal, dbg_state
    );
endinterface

// File: rtl/mc_main_decode.sv
// Combinational opcode classifier for the main control FSM.
module mc_main_decode
    import cpu_defs_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_r,
    output logic       is_i,
    output logic       is_ld,
    output logic       is_st,
    output logic       is_br,
    output logic       is_jal
);

    always_comb begin
        is_r   = 1'b0;
        is_i   = 1'b0;
        is_ld  = 1'b0;
        is_st  = 1'b0;
        is_br  = 1'b0;
        is_jal = 1'b0;
        case (opcode)
            OP_R:    is_r   = 1'b1;
            OP_I:    is_i   = 1'b1;
            OP_LD:   is_ld  = 1'b1;
            OP_ST:   is_st  = 1'b1;
            OP_BR:   is_br  = 1'b1;
            OP_JAL:  is_jal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multicycle CPU: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// datapath enables, mux selects and the ALUop consumed by ALUcontrol.
module mc_control_fsm
    import cpu_defs_pkg::*;
#(
    parameter int unsigned STATE_W = 4,
    parameter bit          DBG_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_control_fsm_if.slave  bus
);

    state_t     state;
    state_t     state_nxt;

    logic       is_r, is_i, is_ld, is_st, is_br, is_jal;

    logic       pc_we_r;
    logic       iord_r;
    logic       mem_rd_r;
    logic       mem_we_r;
    logic       ir_we_r;
    logic       reg_we_r;
    logic [1:0] mem2reg_r;
    logic [1:0] src_a_r;
    logic [1:0] src_b_r;
    logic [1:0] alu_op_r;
    logic       pc_src_r;
    logic       illegal_r;

    mc_main_decode u_decode (
        .opcode (bus.opcode),
        .is_r   (is_r),
        .is_i   (is_i),
        .is_ld  (is_ld),
        .is_st  (is_st),
        .is_br  (is_br),
        .is_jal (is_jal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FETCH;
        else if (bus.cpu_en)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = FETCH;
        pc_we_r   = 1'b0;
        iord_r    = IORD_PC;
        mem_rd_r  = 1'b0;
        mem_we_r  = 1'b0;
        ir_we_r   = 1'b0;
        reg_we_r  = 1'b0;
        mem2reg_r = M2R_ALU;
        src_a_r   = SRCA_PC;
        src_b_r   = SRCB_B;
        alu_op_r  = 2'b00;
        pc_src_r  = PCSRC_ALU;
        illegal_r = 1'b0;

        case (state)
            FETCH: begin
                mem_rd_r  = 1'b1;
                ir_we_r   = 1'b1;
                pc_we_r   = 1'b1;
                iord_r    = IORD_PC;
                src_a_r   = SRCA_PC;
                src_b_r   = SRCB_4;
                alu_op_r  = ALUOP_ADD;
                pc_src_r  = PCSRC_ALU;
                state_nxt = DECODE;
            end
            DECODE: begin
                // Speculative branch/jump target computed while the opcode is classified.
                src_a_r  = SRCA_OLDPC;
                src_b_r  = SRCB_IMM;
                alu_op_r = ALUOP_ADD;
                if (is_r)
                    state_nxt = EXEC_R;
                else if (is_i)
                    state_nxt = EXEC_I;
                else if (is_ld || is_st)
                    state_nxt = MEM_ADDR;
                else if (is_br)
                    state_nxt = BRANCH;
                else if (is_jal)
                    state_nxt = JAL;
                else begin
                    illegal_r = 1'b1;
                    state_nxt = FETCH;
                end
            end
            EXEC_R: begin
                src_a_r   = SRCA_A;
                src_b_r   = SRCB_B;
                alu_op_r  = r_alu_op(bus.func);
                state_nxt = ALU_WB;
            end
            EXEC_I: begin
                src_a_r   = SRCA_A;
                src_b_r   = SRCB_IMM;
                alu_op_r  = (bus.func[2:0] == 3'b100) ? ALUOP_FUNC : ALUOP_ADD;
                state_nxt = ALU_WB;
            end
            ALU_WB: begin
                reg_we_r  = 1'b1;
                mem2reg_r = M2R_ALU;
                state_nxt = FETCH;
            end
            MEM_ADDR: begin
                src_a_r  = SRCA_A;
                src_b_r  = SRCB_IMM;
                alu_op_r = ALUOP_ADD;
                if (is_ld)
                    state_nxt = MEM_READ;
                else if (is_st)
                    state_nxt = MEM_WRITE;
                else
                    state_nxt = FETCH;
            end
            MEM_READ: begin
                mem_rd_r  = 1'b1;
                iord_r    = IORD_ALUOUT;
                state_nxt = MEM_WB;
            end
            MEM_WB: begin
                reg_we_r  = 1'b1;
                mem2reg_r = M2R_MDR;
                state_nxt = FETCH;
            end
            MEM_WRITE: begin
                mem_we_r  = 1'b1;
                iord_r    = IORD_ALUOUT;
                state_nxt = FETCH;
            end
            BRANCH: begin
                src_a_r   = SRCA_A;
                src_b_r   = SRCB_B;
                alu_op_r  = ALUOP_SUB;
                pc_src_r  = PCSRC_ALUOUT;
                pc_we_r   = bus.func[2] ? bus.lt : bus.zero;
                state_nxt = FETCH;
            end
            JAL: begin
                pc_we_r   = 1'b1;
                pc_src_r  = PCSRC_ALUOUT;
                reg_we_r  = 1'b1;
                mem2reg_r = M2R_PC;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Outputs are gated by rst_n so an asserted reset silences everything at once,
    // including the FETCH decode the state register is forced to.
    assign bus.pc_we     = rst_n & bus.cpu_en & pc_we_r;
    assign bus.mem_we    = rst_n & bus.cpu_en & mem_we_r;
    assign bus.ir_we     = rst_n & bus.cpu_en & ir_we_r;
    assign bus.reg_we    = rst_n & bus.cpu_en & reg_we_r;
    assign bus.iord      = rst_n & iord_r;
    assign bus.mem_rd    = rst_n & mem_rd_r;
    assign bus.pc_src    = rst_n & pc_src_r;
    assign bus.illegal   = rst_n & illegal_r;
    assign bus.mem2reg   = rst_n ? mem2reg_r : '0;
    assign bus.alu_src_a = rst_n ? src_a_r   : '0;
    assign bus.alu_src_b = rst_n ? src_b_r   : '0;
    assign bus.alu_op    = rst_n ? alu_op_r  : '0;

    if (DBG_EN) begin : g_dbg
        assign bus.dbg_state = rst_n ? STATE_W'(state) : '0;
    end else begin : g_nodbg
        assign bus.dbg_state = '0;
    end

endmodule
